// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared async-FIFO pointer constants and Gray/binary conversion
package fifo_pkg;

   localparam int FIFO_ADDRSIZE = 6;
   localparam int FIFO_PTR_W    = FIFO_ADDRSIZE + 1;

   // Operates on 32-bit zero-extended values; callers truncate to pointer width.
   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b[31] = g[31];
      for (int i = 30; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/sync_w2r.sv
// rtl/sync_w2r.sv - two-flop synchronizer carrying the Gray write pointer into the read domain
module sync_w2r
   import fifo_pkg::*;
#(
   parameter int WIDTH = FIFO_PTR_W
) (
   input  logic             rd_clk,
   input  logic             rd_rst,
   input  logic [WIDTH-1:0] wr_ptr,
   output logic [WIDTH-1:0] rq2_wptr
);

   logic [WIDTH-1:0] rq1_wptr;

   always_ff @(posedge rd_clk) begin
      if (!rd_rst) begin
         rq1_wptr <= '0;
         rq2_wptr <= '0;
      end else begin
         rq1_wptr <= wr_ptr;
         rq2_wptr <= rq1_wptr;
      end
   end

endmodule

// File: rtl/read_handler.sv
// rtl/read_handler.sv - async FIFO read-side pointer/empty logic; READ_HANDLER_ALMOST_EMPTY_EN adds fill count and almost-empty
module read_handler
   import fifo_pkg::*;
#(
   parameter int ADDRSIZE  = FIFO_ADDRSIZE,
   parameter int AE_THRESH = 4
) (
   input  logic              rd_clk,
   input  logic              rd_rst,
   input  logic              rd_en,
   input  logic [ADDRSIZE:0] wr_ptr,
   output logic [ADDRSIZE:0] rd_addr,
   output logic [ADDRSIZE:0] rd_ptr,
   output logic [ADDRSIZE:0] rq2_wptr,
   output logic              rd_empty,
   output logic              rd_valid,
   output logic              rd_underflow
`ifdef READ_HANDLER_ALMOST_EMPTY_EN
   ,
   output logic [ADDRSIZE:0] rd_count,
   output logic              rd_almost_empty
`endif
);

   localparam int PW = ADDRSIZE + 1;

   if (AE_THRESH < 0 || AE_THRESH > (1 << ADDRSIZE)) begin : g_bad_thresh
      $error("AE_THRESH outside 0..FIFO depth");
   end

   logic          accept;
   logic [PW-1:0] rd_binnext;
   logic [PW-1:0] rd_graynext;

   sync_w2r #(.WIDTH(PW)) u_sync_w2r (
      .rd_clk   (rd_clk),
      .rd_rst   (rd_rst),
      .wr_ptr   (wr_ptr),
      .rq2_wptr (rq2_wptr)
   );

   always_comb begin
      accept      = rd_en & ~rd_empty;
      rd_binnext  = rd_addr + PW'(accept);
      rd_graynext = PW'(bin2gray(32'(rd_binnext)));
   end

   // Empty compares the post-read pointer so the last-word read sets empty on the same edge.
   always_ff @(posedge rd_clk) begin
      if (!rd_rst) begin
         rd_addr      <= '0;
         rd_ptr       <= '0;
         rd_empty     <= 1'b1;
         rd_valid     <= 1'b0;
         rd_underflow <= 1'b0;
      end else begin
         rd_addr      <= rd_binnext;
         rd_ptr       <= rd_graynext;
         rd_empty     <= (rd_graynext == rq2_wptr);
         rd_valid     <= accept;
         rd_underflow <= rd_en & rd_empty;
      end
   end

`ifdef READ_HANDLER_ALMOST_EMPTY_EN
   logic [PW-1:0] fill_next;

   always_comb begin
      fill_next = PW'(gray2bin(32'(rq2_wptr))) - rd_binnext;
   end

   always_ff @(posedge rd_clk) begin
      if (!rd_rst) begin
         rd_count        <= '0;
         rd_almost_empty <= 1'b1;
      end else begin
         rd_count        <= fill_next;
         rd_almost_empty <= (fill_next <= PW'(AE_THRESH));
      end
   end
`endif

endmodule

// File: tb/tb_read_handler.sv
// tb/tb_read_handler.sv - directed self-checking bench for read_handler (ADDRSIZE=6)
module tb_read_handler;

   logic       rd_clk = 1'b0;
   logic       rd_rst;
   logic       rd_en;
   logic [6:0] wr_ptr;
   logic [6:0] rd_addr;
   logic [6:0] rd_ptr;
   logic [6:0] rq2_wptr;
   logic       rd_empty;
   logic       rd_valid;
   logic       rd_underflow;
`ifdef READ_HANDLER_ALMOST_EMPTY_EN
   logic [6:0] rd_count;
   logic       rd_almost_empty;
`endif

   int total = 0;
   int bad   = 0;

   always #5 rd_clk = ~rd_clk;

   read_handler #(.ADDRSIZE(6), .AE_THRESH(4)) dut (
      .rd_clk          (rd_clk),
      .rd_rst          (rd_rst),
      .rd_en           (rd_en),
      .wr_ptr          (wr_ptr),
      .rd_addr         (rd_addr),
      .rd_ptr          (rd_ptr),
      .rq2_wptr        (rq2_wptr),
      .rd_empty        (rd_empty),
      .rd_valid        (rd_valid),
      .rd_underflow    (rd_underflow)
`ifdef READ_HANDLER_ALMOST_EMPTY_EN
      ,
      .rd_count        (rd_count),
      .rd_almost_empty (rd_almost_empty)
`endif
   );

   function automatic logic [6:0] gray7(input logic [6:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic step();
      @(posedge rd_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int         wr_total;
      int         nvalid;
      int         glitch;
      int         onebit_err;
      logic       saw_wrap;
      logic [6:0] prev_ptr;

      // Reset held two edges with rd_en high and a nonzero write pointer
      rd_rst = 1'b0;
      rd_en  = 1'b1;
      wr_ptr = 7'h05;
      step();
      step();
      chk("rst_addr",  32'(rd_addr),      32'h0);
      chk("rst_ptr",   32'(rd_ptr),       32'h0);
      chk("rst_rq2",   32'(rq2_wptr),     32'h0);
      chk("rst_empty", 32'(rd_empty),     32'h1);
      chk("rst_valid", 32'(rd_valid),     32'h0);
      chk("rst_uflow", 32'(rd_underflow), 32'h0);
`ifdef READ_HANDLER_ALMOST_EMPTY_EN
      chk("rst_count", 32'(rd_count),        32'h0);
      chk("rst_ae",    32'(rd_almost_empty), 32'h1);
`endif

      rd_rst = 1'b1;
      rd_en  = 1'b0;
      wr_ptr = 7'h00;
      step();
      step();
      chk("idle_empty", 32'(rd_empty), 32'h1);

      // Single write: sync latency 2, empty drops on 3rd edge
      wr_ptr = 7'h01;
      step();
      chk("sync_e1_rq2", 32'(rq2_wptr), 32'h0);
      step();
      chk("sync_e2_rq2",   32'(rq2_wptr), 32'h1);
      chk("sync_e2_empty", 32'(rd_empty), 32'h1);
      step();
      chk("sync_e3_empty", 32'(rd_empty), 32'h0);

      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      chk("rd1_addr",  32'(rd_addr),  32'h1);
      chk("rd1_ptr",   32'(rd_ptr),   32'h1);
      chk("rd1_valid", 32'(rd_valid), 32'h1);
      chk("rd1_empty", 32'(rd_empty), 32'h1);
      step();
      chk("rd1_valid_pulse", 32'(rd_valid), 32'h0);

      // Read while empty
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      chk("uf_flag",  32'(rd_underflow), 32'h1);
      chk("uf_addr",  32'(rd_addr),      32'h1);
      chk("uf_ptr",   32'(rd_ptr),       32'h1);
      chk("uf_valid", 32'(rd_valid),     32'h0);
      step();
      chk("uf_pulse", 32'(rd_underflow), 32'h0);

      // Stream 130 words through the pointer wrap
      rd_rst = 1'b0;
      wr_ptr = 7'h00;
      step();
      rd_rst = 1'b1;
      step();
      wr_total   = 0;
      nvalid     = 0;
      glitch     = 0;
      onebit_err = 0;
      saw_wrap   = 1'b0;
      prev_ptr   = rd_ptr;
      for (int k = 0; k < 200; k++) begin
         if (wr_total < 130) begin
            wr_total++;
            wr_ptr = gray7(7'(wr_total));
         end
         rd_en = 1'b1;
         step();
         if (rd_valid) begin
            nvalid++;
            if ($countones(prev_ptr ^ rd_ptr) != 1) onebit_err++;
            if (prev_ptr == 7'h40 && rd_ptr == 7'h00) saw_wrap = 1'b1;
         end else if (rd_ptr != prev_ptr) begin
            onebit_err++;
         end
         if (nvalid > 0 && nvalid < 130 && rd_empty) glitch++;
         prev_ptr = rd_ptr;
      end
      rd_en = 1'b0;
      chk("wrap_nvalid",  32'(nvalid),     32'd130);
      chk("wrap_gray1",   32'(onebit_err), 32'd0);
      chk("wrap_seen",    32'(saw_wrap),   32'h1);
      chk("wrap_glitch",  32'(glitch),     32'd0);
      chk("wrap_empty",   32'(rd_empty),   32'h1);
      chk("wrap_addr",    32'(rd_addr),    32'h2);
      chk("wrap_ptr",     32'(rd_ptr),     32'h3);

      // Advance to rd_addr=10 then reset mid-stream
      wr_ptr = gray7(7'd20);
      step();
      step();
      step();
      rd_en = 1'b1;
      for (int k = 0; k < 8; k++) step();
      chk("mid_addr",  32'(rd_addr),  32'd10);
      chk("mid_valid", 32'(rd_valid), 32'h1);
      rd_rst = 1'b0;
      step();
      chk("mrst_addr",  32'(rd_addr),      32'h0);
      chk("mrst_ptr",   32'(rd_ptr),       32'h0);
      chk("mrst_rq2",   32'(rq2_wptr),     32'h0);
      chk("mrst_empty", 32'(rd_empty),     32'h1);
      chk("mrst_valid", 32'(rd_valid),     32'h0);
      chk("mrst_uflow", 32'(rd_underflow), 32'h0);
      rd_rst = 1'b1;
      step();
      step();
      step();
      chk("post_e3_empty", 32'(rd_empty), 32'h0);
      chk("post_e3_valid", 32'(rd_valid), 32'h0);
      step();
      chk("post_e4_valid", 32'(rd_valid), 32'h1);
      chk("post_e4_addr",  32'(rd_addr),  32'h1);
      rd_en = 1'b0;

`ifdef READ_HANDLER_ALMOST_EMPTY_EN
      rd_rst = 1'b0;
      wr_ptr = gray7(7'd6);
      step();
      rd_rst = 1'b1;
      step();
      step();
      step();
      chk("ae_count6", 32'(rd_count),        32'd6);
      chk("ae_flag6",  32'(rd_almost_empty), 32'h0);
      rd_en = 1'b1;
      step();
      step();
      rd_en = 1'b0;
      chk("ae_count4", 32'(rd_count),        32'd4);
      chk("ae_flag4",  32'(rd_almost_empty), 32'h1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
